// File: rtl/aexm_memarb.sv
// Memory arbiter between the instruction and data caches: round-robin grant,
// wrapping critical-word-first line bursts, one beat per acknowledged cycle.
module aexm_memarb #(
  parameter int BURST_LEN = 4
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        ic_req_i,
  input  logic [31:0] ic_addr_i,
  output logic        ic_rvalid_o,
  output logic        ic_done_o,
  input  logic        dc_req_i,
  input  logic        dc_we_i,
  input  logic [31:0] dc_addr_i,
  input  logic [31:0] dc_wdata_i,
  output logic        dc_rvalid_o,
  output logic        dc_wack_o,
  output logic        dc_done_o,
  output logic [31:0] mem_rdata_o,
  output logic        mem_stb_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int LW = $clog2(BURST_LEN);
  // A one-beat line still needs a 1-bit counter; its value is pinned at 0.
  localparam int CW = (LW > 0) ? LW : 1;
  localparam logic [31:0] OFF_MASK  = 32'(BURST_LEN - 1);
  localparam logic [31:0] LINE_MASK = 32'(BURST_LEN * 4 - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DONE} state_t;

  state_t        state_q, state_d;
  logic          stb_q, stb_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [CW-1:0] start_q, start_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_d_q, last_d_d;

  logic          pick_d;
  logic [31:0]   req_addr;
  logic [31:0]   next_off;

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      state_q  <= IDLE;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      start_q  <= '0;
      cnt_q    <= '0;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      stb_q    <= stb_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      start_q  <= start_d;
      cnt_q    <= cnt_d;
      last_d_q <= last_d_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    stb_d    = stb_q;
    we_d     = we_q;
    addr_d   = addr_q;
    start_d  = start_q;
    cnt_d    = cnt_q;
    last_d_d = last_d_q;
    pick_d   = 1'b0;
    req_addr = 32'h0;
    // Word offset of the following beat, wrapped inside the line.
    next_off = (32'(start_q) + 32'(cnt_q) + 32'd1) & OFF_MASK;

    case (state_q)
      IDLE: begin
        if (ic_req_i || dc_req_i) begin
          pick_d   = dc_req_i && (!ic_req_i || !last_d_q);
          req_addr = pick_d ? dc_addr_i : ic_addr_i;
          state_d  = pick_d ? GNT_D : GNT_I;
          addr_d   = req_addr & ~32'h3;
          start_d  = CW'((req_addr >> 2) & OFF_MASK);
          cnt_d    = '0;
          stb_d    = 1'b1;
          we_d     = pick_d & dc_we_i;
        end
      end
      GNT_I, GNT_D: begin
        if (stb_q && mem_ack_i) begin
          if (cnt_q == LAST_CNT) begin
            stb_d    = 1'b0;
            we_d     = 1'b0;
            last_d_d = (state_q == GNT_D);
            state_d  = DONE;
          end else begin
            cnt_d  = cnt_q + CW'(1);
            addr_d = (addr_q & ~LINE_MASK) | (next_off << 2);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // last_d already names the requester just served while in DONE.
  assign ic_done_o   = (state_q == DONE) & ~last_d_q;
  assign dc_done_o   = (state_q == DONE) & last_d_q;
  assign ic_rvalid_o = mem_ack_i & (state_q == GNT_I);
  assign dc_rvalid_o = mem_ack_i & (state_q == GNT_D) & ~we_q;
  assign dc_wack_o   = mem_ack_i & (state_q == GNT_D) & we_q;

  assign mem_rdata_o = mem_rdata_i;
  assign mem_wdata_o = dc_wdata_i;
  assign mem_stb_o   = stb_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;

endmodule

// File: doc/aexm_memarb.md
AEXM_MEMARB -- requirements
Module: aexm_memarb

Interface
REQ-001 Parameter BURST_LEN, default 4, SHALL set beats per line transfer; legal values are powers of two from 1 to 16. LW = log2(BURST_LEN).
REQ-002 sys_clk_i  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 sys_rst_i  in  1  SHALL be the reset: asynchronous, active-low.
REQ-004 ic_req_i  in  1  icache refill request; held until ic_done_o.
REQ-005 ic_addr_i  in  32  icache miss address; stable while ic_req_i is high.
REQ-006 ic_rvalid_o  out  1  read beat for icache is valid on mem_rdata_o this cycle.
REQ-007 ic_done_o  out  1  one-cycle pulse: icache burst complete.
REQ-008 dc_req_i  in  1  dcache request (refill or writeback); held until dc_done_o.
REQ-009 dc_we_i  in  1  1 = writeback, 0 = refill; stable while dc_req_i is high.
REQ-010 dc_addr_i  in  32  dcache miss or writeback address.
REQ-011 dc_wdata_i  in  32  current writeback word.
REQ-012 dc_rvalid_o  out  1  read beat for dcache is valid this cycle.
REQ-013 dc_wack_o  out  1  current writeback word accepted; dcache presents the next word next cycle.
REQ-014 dc_done_o  out  1  one-cycle pulse: dcache burst complete.
REQ-015 mem_rdata_o  out  32  combinational copy of mem_rdata_i, shared by both caches.
REQ-016 mem_stb_o  out  1  registered beat request to memory.
REQ-017 mem_we_o  out  1  registered write qualifier.
REQ-018 mem_addr_o  out  32  registered word address; bits [1:0] are always 0.
REQ-019 mem_wdata_o  out  32  combinational copy of dc_wdata_i.
REQ-020 mem_ack_i  in  1  memory completes the current beat; read data is valid on mem_rdata_i in the same cycle.
REQ-021 mem_rdata_i  in  32  memory read data.

Function
REQ-022 FSM states SHALL be IDLE, GNT_I, GNT_D, DONE.
REQ-023 IDLE transitions:
- only ic_req_i high -> GNT_I.
- only dc_req_i high -> GNT_D.
- both high -> grant the requester not served last, tracked by register last_d.
- neither high -> stay in IDLE.
REQ-024 Grant entry latching:
- latch the requester's address, zero bits [1:0], and set start = addr[LW+1:2].
- clear beat counter cnt.
- set mem_stb_o = 1 and mem_we_o = dc_we_i for GNT_D, 0 for GNT_I.
- mem_stb_o is first visible one cycle after the grant decision.
REQ-025 Beat address SHALL be mem_addr_o = {base[31:LW+2], (start+cnt) mod BURST_LEN, 2'b00}: critical word first, wrapping within the line.
REQ-026 On each cycle with mem_stb_o & mem_ack_i, cnt SHALL increment and mem_addr_o SHALL advance on the next edge; mem_stb_o stays high, giving one beat per cycle under continuous ack.
REQ-027 On the ack where cnt = BURST_LEN-1: clear mem_stb_o and mem_we_o, update last_d, enter DONE.
REQ-028 DONE SHALL pulse the granted requester's done output for exactly one cycle, then return to IDLE.
REQ-029 A request still high in the cycle after its done pulse SHALL be treated as a new request.
REQ-030 Per-beat output qualification:
- ic_rvalid_o = mem_ack_i & state==GNT_I.
- dc_rvalid_o = mem_ack_i & state==GNT_D & ~mem_we_o.
- dc_wack_o = mem_ack_i & state==GNT_D & mem_we_o.
- all three SHALL be 0 in all other cases.
REQ-031 A request dropped mid-burst SHALL be ignored; the burst always completes. mem_ack_i while mem_stb_o=0 SHALL be ignored.
REQ-032 mem_stb_o SHALL be held high with a stable address until acked; there is no timeout.
REQ-033 With BURST_LEN=1, each grant SHALL transfer one beat, and start SHALL be 0 (a zero-width field).

Reset
REQ-034 While sys_rst_i=0, the block SHALL hold: state IDLE, mem_stb_o=0, mem_we_o=0, mem_addr_o=0, cnt=0, start=0, last_d=0, all done/valid/wack outputs 0.
REQ-035 Reset asserted mid-burst SHALL abort immediately with no done pulse; the first grant after reset follows REQ-023 with last_d=0.

Verification
REQ-036 Icache refill:
- stimulus: BURST_LEN=4, ic_req_i=1, ic_addr_i=0x1008, ack every cycle.
- response: mem_addr_o = 0x1008, 0x100C, 0x1000, 0x1004; four ic_rvalid_o pulses; ic_done_o one cycle after the last ack.
REQ-037 Simultaneous requests:
- stimulus: ic_req_i and dc_req_i rise together after reset, both held.
- response: dcache is served first (last_d=0), then icache.
- after further simultaneous requests: grants alternate D, I, D, I.
REQ-038 Writeback with stalls:
- stimulus: dc_we_i=1, dc_addr_i=0x2000, mem_ack_i only on every third cycle.
- response: mem_stb_o and mem_addr_o are stable between acks; dc_wack_o appears exactly at acks; mem_wdata_o tracks dc_wdata_i; four beats at 0x2000..0x200C.
REQ-039 Reset mid-burst:
- stimulus: sys_rst_i=0 asynchronously after beat 2 of a refill.
- response: mem_stb_o=0 and mem_addr_o=0 immediately, without waiting for a clock edge; no done pulse.
- after release with ic_req_i still high: the burst restarts at beat 0.
REQ-040 Request drop and stray ack:
- stimulus: dc_req_i dropped after beat 1; a stray mem_ack_i is driven in IDLE.
- response: the burst completes all four beats and dc_done_o pulses; the stray ack produces no valid or wack pulse and no state change.
